// File: rtl/imem_loader.sv
// imem_loader: boot loader that assembles a big-endian byte stream into 32-bit words,
// writes them to instruction memory at 0, 4, 8, ... and holds the core until done.
module imem_loader #(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);
    typedef enum logic [2:0] {IDLE, LEN, BYTES, WRITE, DONE} state_t;

    state_t      state_q, state_d;
    logic [7:0]  n_q, n_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  idx_q, idx_d;
    logic [31:0] word_q, word_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        xfer;

    assign xfer = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        word_d  = word_q;
        done_d  = done_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (start) begin
                cnt_d   = 8'd0;
                state_d = LEN;
            end
            LEN: if (xfer) begin
                n_d   = in_data;
                idx_d = 2'd0;
                if (in_data == 8'd0) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end else if (in_data > 8'(DEPTH)) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    state_d = BYTES;
                end
            end
            BYTES: if (xfer) begin
                word_d  = {word_q[23:0], in_data};
                idx_d   = idx_q + 2'd1;
                state_d = (idx_q == 2'd3) ? WRITE : BYTES;
            end
            WRITE: begin
                cnt_d   = cnt_q + 8'd1;
                done_d  = (cnt_q + 8'd1 == n_q);
                state_d = (cnt_q + 8'd1 == n_q) ? DONE : BYTES;
            end
            DONE: if (start) begin
                done_d  = 1'b0;
                err_d   = 1'b0;
                cnt_d   = 8'd0;
                state_d = LEN;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            n_q     <= 8'd0;
            cnt_q   <= 8'd0;
            idx_q   <= 2'd0;
            word_q  <= 32'd0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign in_ready   = (state_q == LEN) || (state_q == BYTES);
    assign imem_we    = (state_q == WRITE);
    assign imem_addr  = ADDR_W'({cnt_q, 2'b00});
    assign imem_wdata = word_q;
    assign cpu_hold   = (state_q != DONE);
    assign busy       = (state_q == LEN) || (state_q == BYTES) || (state_q == WRITE);
    assign done       = done_q;
    assign err        = err_q;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: table-driven loads with a write scoreboard, plus reset and restart corner cases.
module tb_imem_loader;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 8;

    logic              clk = 1'b0;
    logic              rst_n, start, in_valid;
    logic [7:0]        in_data;
    logic              in_ready, imem_we, cpu_hold, busy, done, err;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]       n;
        logic [7:0][31:0] w;
        bit               tog;
        bit               mstart;
        bit               exp_done;
        bit               exp_err;
    } vec_t;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int wcnt   = 0;
    int wcyc[$];
    logic [ADDR_W+31:0] exp_q[$];
    vec_t tv[7];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Scoreboard: every write pulse must match the oldest expected {addr, data}.
    always @(negedge clk) begin
        if (imem_we) begin
            logic [ADDR_W+31:0] e;
            wcnt++;
            wcyc.push_back(cyc);
            checks++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_we addr=%h data=%h exp=none", imem_addr, imem_wdata);
            end else begin
                e = exp_q.pop_front();
                if ({imem_addr, imem_wdata} !== e) begin
                    fails++;
                    $display("FAIL write got=%h_%h exp=%h_%h", imem_addr, imem_wdata,
                             e[ADDR_W+31:32], e[31:0]);
                end
            end
            chk("hold_during_we", {31'd0, cpu_hold}, 32'd1);
        end
    end

    task automatic send(input logic [7:0] b, input bit tog);
        int t = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (!in_ready) begin
            fails++;
            $display("FAIL send_timeout got=ready0 exp=ready1");
        end
        @(negedge clk);
        if (tog) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_busy", {31'd0, busy}, 32'd1);
        chk("start_ready", {31'd0, in_ready}, 32'd1);
        chk("start_flags", {30'd0, done, err}, 32'd0);
        chk("start_hold", {31'd0, cpu_hold}, 32'd1);
    endtask

    task automatic run_load(input vec_t v);
        int t = 0;
        int nw;
        do_start();
        wcnt = 0;
        wcyc.delete();
        send(v.n, v.tog);
        nw = (v.n <= 8'(DEPTH)) ? int'(v.n) : 0;
        for (int i = 0; i < nw; i++) begin
            for (int j = 0; j < 4; j++) begin
                if (j == 3) exp_q.push_back({ADDR_W'(i * 4), v.w[i]});
                if (v.mstart && i == 0 && j == 2) start = 1'b1;
                send(v.w[i][31-8*j -: 8], v.tog);
                start = 1'b0;
            end
        end
        in_valid = 1'b0;
        while (busy && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("load_busy", {31'd0, busy}, 32'd0);
        chk("load_done", {31'd0, done}, {31'd0, v.exp_done});
        chk("load_err", {31'd0, err}, {31'd0, v.exp_err});
        chk("load_hold", {31'd0, cpu_hold}, 32'd0);
        chk("load_ready", {31'd0, in_ready}, 32'd0);
        chk("load_wcnt", wcnt, nw);
        chk("load_q_empty", exp_q.size(), 0);
        if (wcnt > 0) chk("done_latency", cyc - wcyc[wcyc.size()-1], 1);
        if (!v.tog)
            for (int k = 1; k < wcyc.size(); k++) chk("we_gap", wcyc[k] - wcyc[k-1], 5);
    endtask

    function automatic vec_t mk(input logic [7:0] n, input logic [31:0] w0, input logic [31:0] w1,
                                input bit tog, input bit ms, input bit d, input bit e);
        vec_t v;
        v.n = n;
        v.w = '0;
        v.w[0] = w0;
        v.w[1] = w1;
        v.tog = tog;
        v.mstart = ms;
        v.exp_done = d;
        v.exp_err = e;
        return v;
    endfunction

    initial begin
        vec_t r;
        tv[0] = mk(8'd2, 32'h20080005, 32'h20090007, 1'b0, 1'b0, 1'b1, 1'b0);
        tv[1] = mk(8'd2, 32'h20080005, 32'h20090007, 1'b1, 1'b0, 1'b1, 1'b0);
        tv[2] = mk(8'd9, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        tv[3] = mk(8'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        tv[4] = mk(8'd8, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) tv[4].w[i] = 32'hA0000000 + i * 32'h01020304;
        tv[5] = mk(8'd2, 32'hCAFEF00D, 32'h12345678, 1'b0, 1'b1, 1'b1, 1'b0);
        tv[6] = mk(8'd1, 32'hDEADBEEF, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);

        rst_n = 1'b0;
        start = 1'b0;
        in_valid = 1'b0;
        in_data = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_we", {31'd0, imem_we}, 32'd0);
        chk("rst_addr", {27'd0, imem_addr}, 32'd0);
        chk("rst_wdata", imem_wdata, 32'd0);
        chk("rst_hold", {31'd0, cpu_hold}, 32'd1);
        chk("rst_flags", {29'd0, busy, done, err}, 32'd0);
        rst_n = 1'b1;
        in_valid = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_ready", {31'd0, in_ready}, 32'd0);
        chk("idle_hold", {31'd0, cpu_hold}, 32'd1);
        in_valid = 1'b0;

        for (int i = 0; i < 7; i++) run_load(tv[i]);

        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("done_sticky", {31'd0, done}, 32'd1);
        chk("done_no_ready", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;

        do_start();
        wcnt = 0;
        send(8'd3, 1'b0);
        exp_q.push_back({ADDR_W'(0), 32'h11223344});
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        send(8'h44, 1'b0);
        send(8'h55, 1'b0);
        send(8'h66, 1'b0);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_hold", {31'd0, cpu_hold}, 32'd1);
        chk("mid_rst_ready", {31'd0, in_ready}, 32'd0);
        chk("mid_rst_we", {31'd0, imem_we}, 32'd0);
        chk("mid_rst_flags", {30'd0, done, err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("mid_rst_wcnt", wcnt, 1);
        chk("mid_rst_idle_hold", {31'd0, cpu_hold}, 32'd1);
        r = mk(8'd1, 32'h0BADC0DE, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        run_load(r);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end
endmodule
